// File: rtl/wshb_arbiter2.sv
// Two-master Wishbone arbiter in front of a shared SDRAM slave.
// Round-robin on contention, bursts are never preempted, and a finishing
// master hands the bus straight to a waiting one without an idle cycle.
module wshb_arbiter2 #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (frame reader)
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_ms,
  input  logic [DW/8-1:0] m0_sel,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_dat_sm,
  // master 1 (pattern writer)
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_ms,
  input  logic [DW/8-1:0] m1_sel,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_dat_sm,
  // shared slave
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_ms,
  output logic [DW/8-1:0] s_sel,
  input  logic            s_ack,
  input  logic [DW-1:0]   s_dat_sm,
  // one-hot grant
  output logic [1:0]      gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // 0 = m0 was granted most recently, 1 = m1; reset to 1 so m0 wins first
  logic   last_q, last_d;

  // State and round-robin pointer registers; reset aborts any grant in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state decision uses only cyc lines, never s_ack
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
        else                  state_d = IDLE;
      end
      GNT0: begin
        if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc) state_d = GNT1;
        else             state_d = IDLE;
      end
      GNT1: begin
        if (m1_cyc)      state_d = GNT1;
        else if (m0_cyc) state_d = GNT0;
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pointer follows every new grant; re-writing the same value while
    // holding a grant is harmless
    if (state_d == GNT0) last_d = 1'b0;
    if (state_d == GNT1) last_d = 1'b1;
  end

  // Route the granted master onto the slave bus and steer ack back to it
  always_comb begin
    gnt      = 2'b00;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    unique case (state_q)
      GNT0: begin
        gnt      = 2'b01;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        m0_ack   = s_ack;
      end
      GNT1: begin
        gnt      = 2'b10;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        m1_ack   = s_ack;
      end
      default: ;
    endcase
  end

  // Read data is a shared bus; each master qualifies it with its own ack
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Directed bench for wshb_arbiter2: a vector table plus burst sequences.
module tb_wshb_arbiter2;
  localparam int DW = 32;
  localparam int AW = 32;

  localparam logic [AW-1:0] M0_ADR = 32'h0000_1000;
  localparam logic [AW-1:0] M1_ADR = 32'h0000_2000;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_cyc, m0_stb, m0_we;
  logic [AW-1:0]   m0_adr;
  logic [DW-1:0]   m0_dat_ms;
  logic [DW/8-1:0] m0_sel;
  logic            m0_ack;
  logic [DW-1:0]   m0_dat_sm;
  logic            m1_cyc, m1_stb, m1_we;
  logic [AW-1:0]   m1_adr;
  logic [DW-1:0]   m1_dat_ms;
  logic [DW/8-1:0] m1_sel;
  logic            m1_ack;
  logic [DW-1:0]   m1_dat_sm;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_ms;
  logic [DW/8-1:0] s_sel;
  logic            s_ack;
  logic [DW-1:0]   s_dat_sm;
  logic [1:0]      gnt;

  int checks = 0;
  int errors = 0;

  wshb_arbiter2 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
    .gnt(gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       c0;
    logic       c1;
    logic       ack;
    logic [1:0] gnt;
    logic       a0;
    logic       a1;
    logic       scyc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic c0, input logic c1, input logic ak,
                     input logic [1:0] g, input logic a0, input logic a1, input logic sc);
    vec_t v;
    v.rst = r; v.c0 = c0; v.c1 = c1; v.ack = ak;
    v.gnt = g; v.a0 = a0; v.a1 = a1; v.scyc = sc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] prev_g, exp_g;
    int ep_acks, ngr, c0n, c1n, acks;
    logic drop0, drop1;

    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b0; m0_adr = M0_ADR; m0_dat_ms = 32'h1111_0000; m0_sel = 4'hF;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b1; m1_adr = M1_ADR; m1_dat_ms = 32'h2222_0000; m1_sel = 4'h3;
    s_ack = 0; s_dat_sm = '0;

    // rst c0 c1 ack | gnt a0 a1 s_cyc  (outputs seen before the clock edge)
    add(1, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 1, 1, 1, 2'b00, 0, 0, 0);
    add(0, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 1, 1, 1, 2'b01, 1, 0, 1);
    add(0, 0, 1, 0, 2'b01, 0, 0, 0);
    add(0, 0, 1, 1, 2'b10, 0, 1, 1);
    add(0, 0, 0, 0, 2'b10, 0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 0, 0, 0);
    add(0, 1, 0, 0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 2'b01, 0, 0, 0);
    add(0, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 1, 1, 1, 2'b10, 0, 1, 1);
    add(0, 1, 0, 0, 2'b10, 0, 0, 0);
    add(0, 1, 0, 1, 2'b01, 1, 0, 1);
    add(1, 1, 0, 1, 2'b01, 1, 0, 1);
    add(0, 0, 1, 1, 2'b00, 0, 0, 0);
    add(0, 0, 1, 0, 2'b10, 0, 0, 1);
    add(0, 0, 0, 0, 2'b10, 0, 0, 0);
    add(0, 1, 1, 0, 2'b00, 0, 0, 0);
    add(0, 1, 1, 0, 2'b01, 0, 0, 1);

    foreach (vecs[i]) begin
      logic [AW-1:0] exp_adr;
      logic          exp_we;
      @(negedge clk);
      rst = vecs[i].rst;
      m0_cyc = vecs[i].c0; m0_stb = vecs[i].c0;
      m1_cyc = vecs[i].c1; m1_stb = vecs[i].c1;
      s_ack = vecs[i].ack;
      s_dat_sm = 32'hC0DE_0000 + 32'(i);
      #1;
      exp_adr = (vecs[i].gnt == 2'b01) ? M0_ADR : (vecs[i].gnt == 2'b10) ? M1_ADR : '0;
      exp_we  = (vecs[i].gnt == 2'b10);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].a0));
      check($sformatf("vec%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].a1));
      check($sformatf("vec%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].scyc));
      check($sformatf("vec%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].scyc));
      check($sformatf("vec%0d_s_adr", i), s_adr, exp_adr);
      check($sformatf("vec%0d_s_we", i), 32'(s_we), 32'(exp_we));
      check($sformatf("vec%0d_dat_sm", i), m1_dat_sm, 32'hC0DE_0000 + 32'(i));
    end

    // 64-beat m1 write burst; m0 arrives at beat 10 and must wait it out
    do_reset();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #1 check("burst_idle_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    acks = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin m0_cyc = 1; m0_stb = 1; end
      #1;
      check("burst_gnt", 32'(gnt), 32'h2);
      check("burst_m0_ack", 32'(m0_ack), 32'h0);
      check("burst_s_we", 32'(s_we), 32'h1);
      if (m1_ack) acks++;
      @(negedge clk);
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    #1;
    check("burst_ack_count", 32'(acks), 32'd64);
    check("burst_end_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    #1;
    check("burst_handover_gnt", 32'(gnt), 32'h1);
    check("burst_handover_adr", s_adr, M0_ADR);
    m0_cyc = 0; m0_stb = 0;

    // Both masters stream 4-beat bursts back to back; grants must alternate
    do_reset();
    prev_g = 2'b00; exp_g = 2'b01; ngr = 0; ep_acks = 0;
    c0n = 0; c1n = 0; drop0 = 0; drop1 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      m0_cyc = !drop0; m0_stb = !drop0;
      m1_cyc = !drop1; m1_stb = !drop1;
      drop0 = 0; drop1 = 0;
      #1 s_ack = s_stb;
      #1;
      if (gnt != prev_g) begin
        if (prev_g != 2'b00) check("rr_acks_per_grant", 32'(ep_acks), 32'd4);
        if (gnt != 2'b00) begin
          check("rr_grant_order", 32'(gnt), 32'(exp_g));
          exp_g = {exp_g[0], exp_g[1]};
          ngr++;
        end
        ep_acks = 0;
        prev_g = gnt;
      end
      check("rr_ack_onehot", 32'(m0_ack & m1_ack), 32'h0);
      if (m0_ack) begin ep_acks++; c0n++; if (c0n == 4) begin drop0 = 1; c0n = 0; end end
      if (m1_ack) begin ep_acks++; c1n++; if (c1n == 4) begin drop1 = 1; c1n = 0; end end
    end
    check("rr_grant_count", 32'(ngr), 32'd8);

    // Read-data steering and a waiting, un-granted master
    do_reset();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; s_dat_sm = 32'hA5A5_A5A5;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; s_ack = 1;
    #1;
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_m0_ack", 32'(m0_ack), 32'h1);
    check("rd_m1_ack_waiting", 32'(m1_ack), 32'h0);
    check("rd_m0_dat", m0_dat_sm, 32'hA5A5_A5A5);
    check("rd_m1_dat", m1_dat_sm, 32'hA5A5_A5A5);
    @(negedge clk);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1 check("wait_m1_ack", 32'(m1_ack), 32'h0);
    @(negedge clk);
    s_ack = 1;
    #1;
    check("wait_m1_gnt", 32'(gnt), 32'h2);
    check("wait_m1_ack_now", 32'(m1_ack), 32'h1);
    check("wait_m0_ack_now", 32'(m0_ack), 32'h0);
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wshb_arbiter2.md
WSHB_ARBITER2 -- requirements
Module: wshb_arbiter2

Interface
REQ-001 SHALL expose parameter DW, default 32, data width of all dat_ms/dat_sm buses.
REQ-002 SHALL expose parameter AW, default 32, address width of all adr buses.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port m0_cyc  input  1  master 0 (frame reader) cycle request.
REQ-006 SHALL have port m0_stb  input  1  master 0 strobe.
REQ-007 SHALL have port m0_we  input  1  master 0 write enable.
REQ-008 SHALL have port m0_adr  input  AW  master 0 byte address.
REQ-009 SHALL have port m0_dat_ms  input  DW  master 0 write data.
REQ-010 SHALL have port m0_sel  input  DW/8  master 0 byte selects.
REQ-011 SHALL have port m0_ack  output  1  master 0 acknowledge.
REQ-012 SHALL have port m0_dat_sm  output  DW  master 0 read data.
REQ-013 SHALL have ports m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel (inputs) and m1_ack, m1_dat_sm (outputs), same widths and meaning, master 1 (pattern writer).
REQ-014 SHALL have ports s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel (outputs) and s_ack, s_dat_sm (inputs), same widths, to the shared SDRAM slave.
REQ-015 SHALL have port gnt  output  2  one-hot current grant (bit0 = m0, bit1 = m1, 00 = none).

Function
REQ-016 SHALL implement a registered FSM with states IDLE, GNT0, GNT1; gnt SHALL equal 00/01/10 respectively.
REQ-017 SHALL hold a 1-bit register last recording the most recently granted master.
REQ-018 In IDLE, only m0_cyc=1: next state GNT0; only m1_cyc=1: next state GNT1; neither: stay IDLE.
REQ-019 In IDLE with both cyc=1: next state SHALL grant the master not equal to last (round-robin).
REQ-020 In GNTx while mx_cyc=1: SHALL stay in GNTx regardless of the other master (no preemption, bursts are atomic).
REQ-021 In GNTx when mx_cyc=0: if the other master's cyc=1, next state SHALL be its GNT state directly (no IDLE cycle); else IDLE.
REQ-022 On every entry into GNTx, last SHALL be set to x.
REQ-023 Grant latency: cyc asserted in cycle N from IDLE SHALL appear on s_cyc in cycle N+1.
REQ-024 In GNTx, s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel SHALL combinationally equal master x's signals.
REQ-025 In IDLE, s_cyc and s_stb SHALL be 0; s_we, s_adr, s_dat_ms, s_sel SHALL be 0.
REQ-026 mx_ack SHALL equal s_ack only in GNTx; otherwise 0. s_ack in IDLE SHALL be ignored.
REQ-027 m0_dat_sm and m1_dat_sm SHALL both equal s_dat_sm (shared bus, qualified by ack).
REQ-028 A master whose stb is high while not granted SHALL receive no ack and SHALL keep waiting; no request is dropped.
REQ-029 cyc toggling of the non-granted master SHALL not affect the current grant.
REQ-030 No combinational path SHALL exist from s_ack to the FSM next-state logic.

Reset
REQ-031 While rst=1 at a clock edge: state IDLE, last=1 (so m0 wins first contention), gnt=00.
REQ-032 During and after reset until the first grant: s_cyc=0, s_stb=0, m0_ack=0, m1_ack=0.
REQ-033 rst asserted mid-burst SHALL abort the grant at that edge; the master is responsible for restarting.

Verification
REQ-034 Reset, then m0_cyc=m1_cyc=1 in same cycle -> gnt=01 next cycle, s_adr=m0_adr; after m0_cyc drops -> gnt=10 next cycle with no IDLE cycle.
REQ-035 m1 alone issues 64-beat write burst (cyc held, slave acks every cycle); m0_cyc rises at beat 10 -> gnt stays 10 for all 64 acks, m0_ack=0 throughout, then gnt=01.
REQ-036 Both masters request continuously with 4-beat bursts each -> grants alternate 01,10,01,10; each master receives exactly 4 acks per grant.
REQ-037 Grant GNT0, s_ack=1 pulsed -> m0_ack=1, m1_ack=0, m0_dat_sm=s_dat_sm=32'hA5A5A5A5.
REQ-038 rst=1 for one cycle in middle of an m0 burst -> next cycle gnt=00, s_cyc=0; m1 then requesting alone -> gnt=10 one cycle after reset release.
